audio_frame_interleaver: RTL

Parametrised N-channel lockstep drain for the FM radio audio outputs. It pops one sample from every channel output FIFO in the same cycle, but only when all of them are non-empty. It then serialises the captured frame onto a single valid/ready stream tagged with channel index. It counts frames and stops after a programmable limit, giving the FM radio top a single ordered audio sink for any channel count.

---
 rtl/audio_frame_interleaver.sv | 107 ++++++++++
 1 files changed

// File: rtl/audio_frame_interleaver.sv
// rtl/audio_frame_interleaver.sv - lockstep N-channel FIFO drain serialised onto one tagged stream
module audio_frame_interleaver #(
    parameter int DATA_SIZE    = 32,
    parameter int NUM_CHANNELS = 2,
    parameter int CH_BITS      = 3,
    parameter int FCW          = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [FCW-1:0]                    frame_limit,
    input  logic [NUM_CHANNELS-1:0]           ch_empty,
    input  logic [NUM_CHANNELS*DATA_SIZE-1:0] ch_dout,
    output logic [NUM_CHANNELS-1:0]           ch_rd_en,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_SIZE-1:0]              out_data,
    output logic [CH_BITS-1:0]                out_channel,
    output logic                              out_last,
    output logic [FCW-1:0]                    frames_done,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CHANNELS - 1);

    state_t                            state;
    logic [FCW-1:0]                    limit_q;
    // Captured frame; the channel currently on the output always sits in the low slot.
    logic [NUM_CHANNELS*DATA_SIZE-1:0] frame_buf;
    logic                              frame_ready;
    logic [CH_BITS-1:0]                next_ch;
    logic [FCW-1:0]                    next_count;

    // A frame may only be popped when every channel has a sample, so pops are never partial.
    assign frame_ready = ~|ch_empty;
    assign ch_rd_en    = {NUM_CHANNELS{(state == ST_WAIT) && frame_ready}};
    assign next_ch     = out_channel + 1'b1;
    assign next_count  = frames_done + 1'b1;
    assign out_data    = frame_buf[DATA_SIZE-1:0];
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);

    // Run control, frame capture and serialisation of the captured frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            limit_q     <= '0;
            frame_buf   <= '0;
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_last    <= 1'b0;
            frames_done <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        frames_done <= '0;
                        if (frame_limit != '0) begin
                            limit_q <= frame_limit;
                            state   <= ST_WAIT;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (frame_ready) begin
                        frame_buf   <= ch_dout;
                        out_channel <= '0;
                        out_last    <= (NUM_CHANNELS == 1);
                        out_valid   <= 1'b1;
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (!out_last) begin
                            frame_buf   <= frame_buf >> DATA_SIZE;
                            out_channel <= next_ch;
                            out_last    <= (next_ch == LAST_CH);
                        end else begin
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            frames_done <= next_count;
                            state       <= (next_count == limit_q) ? ST_DONE : ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
